// File: rtl/wave_pkg.sv
// rtl/wave_pkg.sv - shared constants, state enum and phase-to-index helper for wave_player
package wave_pkg;

    localparam int BITWIDTH = 9;
    localparam int DEPTH    = 360;
    localparam int ADDR_W   = 9;
    localparam int PHASE_W  = 24;
    localparam int DIV      = 4;
    localparam int DIV_W    = $clog2(DIV);

    localparam logic [ADDR_W-1:0]   DEPTH_A  = ADDR_W'(DEPTH);
    localparam logic [BITWIDTH-1:0] MIDSCALE = BITWIDTH'((1 << (BITWIDTH - 1)) - 1);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        PLAY = 2'd1,
        ERR  = 2'd2
    } state_e;

    // Top 16 phase bits scaled onto 0..DEPTH-1; the product's upper ADDR_W bits
    // are floor(p16 * DEPTH / 2^16), which is always below DEPTH.
    function automatic logic [ADDR_W-1:0] phase_to_index(input logic [PHASE_W-1:0] phase);
        logic [16+ADDR_W-1:0] prod;
        prod = {{ADDR_W{1'b0}}, phase[PHASE_W-1 -: 16]} * {16'b0, DEPTH_A};
        return prod[16 +: ADDR_W];
    endfunction

endpackage

// File: rtl/wave_ram.sv
// rtl/wave_ram.sv - DEPTH x BITWIDTH simple dual-port RAM with registered read
// Ports: clk; wr_en/wr_addr/wr_data write port; rd_en/rd_addr read request,
//        rd_data valid the cycle after rd_en and held while rd_en is low.
module wave_ram
    import wave_pkg::*;
(
    input  logic                clk,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [BITWIDTH-1:0] wr_data,
    input  logic                rd_en,
    input  logic [ADDR_W-1:0]   rd_addr,
    output logic [BITWIDTH-1:0] rd_data
);

    logic [BITWIDTH-1:0] mem [DEPTH];
    logic [BITWIDTH-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/wave_player.sv
// rtl/wave_player.sv - captures a waveform table and replays it with a DDS phase accumulator
// Optional macro WAVE_PLAYER_AMPLITUDE_EN adds the amp gain port and one output stage.
// Ports: clk, rst_n (async, active-low)
//        in_data/in_v/in_done : table load (in_data valid the cycle after in_v)
//        freq_word/freq_load  : phase increment, taken at the next sample tick
//        run                  : playback enable, 0 plays midscale
//        amp                  : unsigned gain (WAVE_PLAYER_AMPLITUDE_EN only)
//        out_sample/out_v     : DAC sample and new-sample strobe
//        ready/ovf/err        : table loaded / overflow (sticky) / short table (sticky)
module wave_player
    import wave_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic [BITWIDTH-1:0] in_data,
    input  logic                in_v,
    input  logic                in_done,
    input  logic [PHASE_W-1:0]  freq_word,
    input  logic                freq_load,
    input  logic                run,
`ifdef WAVE_PLAYER_AMPLITUDE_EN
    input  logic [7:0]          amp,
`endif
    output logic [BITWIDTH-1:0] out_sample,
    output logic                out_v,
    output logic                ready,
    output logic                ovf,
    output logic                err
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    state_e              state_q, state_d;
    logic                in_v_q, in_v_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic                ready_q, ready_d;
    logic                ovf_q, ovf_d;
    logic                err_q, err_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [PHASE_W-1:0]  phase_q, phase_d;
    logic [PHASE_W-1:0]  freq_q, freq_d;
    logic [PHASE_W-1:0]  pend_q, pend_d;
    logic                pend_v_q, pend_v_d;
    logic [ADDR_W-1:0]   idx_q, idx_d;
    logic                v1_q, v1_d;     // stage 1: index registered
    logic                mid1_q, mid1_d; // stage 1 sample is forced midscale
    logic                v2_q, v2_d;     // stage 2: RAM data available
    logic                src_q, src_d;   // 1 = out sample comes from RAM

    logic                tick;
    logic                wr_en;
    logic                rd_en;
    logic [PHASE_W-1:0]  inc;
    logic [BITWIDTH-1:0] rd_data;
    logic [BITWIDTH-1:0] raw_sample;

    wave_ram u_ram (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr_q),
        .wr_data (in_data),
        .rd_en   (rd_en),
        .rd_addr (idx_q),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d   = state_q;
        in_v_d    = in_v;
        wr_addr_d = wr_addr_q;
        ready_d   = ready_q;
        ovf_d     = ovf_q;
        err_d     = err_q;
        div_d     = div_q;
        phase_d   = phase_q;
        freq_d    = freq_q;
        pend_d    = pend_q;
        pend_v_d  = pend_v_q;
        idx_d     = idx_q;
        mid1_d    = mid1_q;
        src_d     = src_q;
        wr_en     = 1'b0;
        tick      = (state_q == PLAY) && (div_q == '0);
        // A frequency loaded before this tick takes effect at this tick.
        inc       = pend_v_q ? pend_q : freq_q;

        case (state_q)
            LOAD: begin
                if (in_v_q) begin
                    if (wr_addr_q < DEPTH_A) begin
                        wr_en     = 1'b1;
                        wr_addr_d = wr_addr_q + 1'b1;
                    end else begin
                        ovf_d = 1'b1;
                    end
                end
                // Completion is only judged once no strobe is in flight.
                if (in_done && !in_v_q && !in_v) begin
                    if (wr_addr_q == DEPTH_A) begin
                        state_d = PLAY;
                        ready_d = 1'b1;
                    end else begin
                        state_d = ERR;
                        err_d   = 1'b1;
                    end
                end
            end
            PLAY: begin
                div_d = (div_q == DIV_LAST) ? '0 : div_q + 1'b1;
            end
            default: begin
            end
        endcase

        if (tick) begin
            freq_d   = inc;
            pend_v_d = 1'b0;
            idx_d    = phase_to_index(phase_q);
            mid1_d   = !run;
            phase_d  = run ? phase_q + inc : '0;
        end
        // Placed after the tick so a load coinciding with a tick waits for the next one.
        if (freq_load) begin
            pend_d   = freq_word;
            pend_v_d = 1'b1;
        end

        v1_d = tick;
        v2_d = v1_q;
        if (v1_q) begin
            src_d = !mid1_q;
        end
        // Read only for real samples so rd_data holds between strobes.
        rd_en = v1_q && !mid1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= LOAD;
            in_v_q    <= 1'b0;
            wr_addr_q <= '0;
            ready_q   <= 1'b0;
            ovf_q     <= 1'b0;
            err_q     <= 1'b0;
            div_q     <= '0;
            phase_q   <= '0;
            freq_q    <= '0;
            pend_q    <= '0;
            pend_v_q  <= 1'b0;
            idx_q     <= '0;
            v1_q      <= 1'b0;
            mid1_q    <= 1'b1;
            v2_q      <= 1'b0;
            src_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            in_v_q    <= in_v_d;
            wr_addr_q <= wr_addr_d;
            ready_q   <= ready_d;
            ovf_q     <= ovf_d;
            err_q     <= err_d;
            div_q     <= div_d;
            phase_q   <= phase_d;
            freq_q    <= freq_d;
            pend_q    <= pend_d;
            pend_v_q  <= pend_v_d;
            idx_q     <= idx_d;
            v1_q      <= v1_d;
            mid1_q    <= mid1_d;
            v2_q      <= v2_d;
            src_q     <= src_d;
        end
    end

    assign raw_sample = src_q ? rd_data : MIDSCALE;

`ifdef WAVE_PLAYER_AMPLITUDE_EN
    localparam int PROD_W = BITWIDTH + 10;
    localparam logic signed [PROD_W-1:0] MID_S = PROD_W'(MIDSCALE);
    localparam logic signed [PROD_W-1:0] MAX_S = PROD_W'((1 << BITWIDTH) - 1);

    logic signed [BITWIDTH:0]   diff;
    logic signed [PROD_W-1:0]   prod;
    logic signed [PROD_W-1:0]   scaled;
    logic [BITWIDTH-1:0]        out_sample_q, out_sample_d;
    logic                       out_v_q, out_v_d;

    always_comb begin
        diff         = $signed({1'b0, raw_sample}) - $signed({1'b0, MIDSCALE});
        prod         = PROD_W'(diff) * $signed({{(PROD_W-8){1'b0}}, amp});
        scaled       = (prod >>> 8) + MID_S;
        out_v_d      = v2_q;
        out_sample_d = out_sample_q;
        if (v2_q) begin
            if (scaled[PROD_W-1]) begin
                out_sample_d = '0;
            end else if (scaled > MAX_S) begin
                out_sample_d = '1;
            end else begin
                out_sample_d = scaled[BITWIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_sample_q <= MIDSCALE;
            out_v_q      <= 1'b0;
        end else begin
            out_sample_q <= out_sample_d;
            out_v_q      <= out_v_d;
        end
    end

    assign out_sample = out_sample_q;
    assign out_v      = out_v_q;
`else
    assign out_sample = raw_sample;
    assign out_v      = v2_q;
`endif

    assign ready = ready_q;
    assign ovf   = ovf_q;
    assign err   = err_q;

endmodule

// File: tb/tb_wave_player.sv
// tb/tb_wave_player.sv - self-checking bench for wave_player (vectors, sequences, random vs model)
module tb_wave_player;
    import wave_pkg::*;

`ifdef WAVE_PLAYER_AMPLITUDE_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic                clk = 1'b0;
    logic                rst_n;
    logic [BITWIDTH-1:0] in_data;
    logic                in_v;
    logic                in_done;
    logic [PHASE_W-1:0]  freq_word;
    logic                freq_load;
    logic                run;
    logic [7:0]          amp;
    logic [BITWIDTH-1:0] out_sample;
    logic                out_v;
    logic                ready;
    logic                ovf;
    logic                err;

    always #5 clk = ~clk;

    wave_player dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_data    (in_data),
        .in_v       (in_v),
        .in_done    (in_done),
        .freq_word  (freq_word),
        .freq_load  (freq_load),
        .run        (run),
`ifdef WAVE_PLAYER_AMPLITUDE_EN
        .amp        (amp),
`endif
        .out_sample (out_sample),
        .out_v      (out_v),
        .ready      (ready),
        .ovf        (ovf),
        .err        (err)
    );

    int total = 0;
    int bad   = 0;

    // Reference model state
    int vals [DEPTH + 1];
    int tbl  [DEPTH];
    int m_phase, m_freq, m_pend, m_pend_v;
    int c, cyc, last;

    typedef struct {
        int due;
        int val;
    } exp_t;
    exp_t expq [$];
    int   got  [$];

    typedef struct {
        logic [PHASE_W-1:0] word;
        int e0, e1, e2, e3;
    } vec_t;
    vec_t vecs [5];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Gain applied as mid + floor((s - mid) * amp / 256), clamped to the sample range.
    function automatic int scale(input int s);
`ifdef WAVE_PLAYER_AMPLITUDE_EN
        int d, q, r;
        d = (s - int'(MIDSCALE)) * int'(amp);
        q = (d >= 0) ? d / 256 : -((-d + 255) / 256);
        r = int'(MIDSCALE) + q;
        if (r < 0) r = 0;
        if (r > (1 << BITWIDTH) - 1) r = (1 << BITWIDTH) - 1;
        return r;
`else
        return s;
`endif
    endfunction

    task automatic do_reset();
        rst_n     = 1'b0;
        in_v      = 1'b0;
        in_done   = 1'b0;
        in_data   = '0;
        freq_load = 1'b0;
        freq_word = '0;
        run       = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_sample", int'(out_sample), 255);
        chk("rst_out_v", int'(out_v), 0);
        chk("rst_ready", int'(ready), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_err", int'(err), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        c = 0; cyc = 0; last = int'(MIDSCALE);
        m_phase = 0; m_freq = 0; m_pend = 0; m_pend_v = 0;
        expq.delete();
        got.delete();
    endtask

    // Strobe then data on the following cycle, one strobe every gap cycles.
    task automatic load(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1 in_v = 1'b1;
            @(posedge clk); #1 in_v = 1'b0; in_data = BITWIDTH'(vals[i]);
            if (i < DEPTH) tbl[i] = vals[i];
            repeat (gap - 2) @(posedge clk);
        end
        @(posedge clk); #1 in_data = '0;
    endtask

    // One clock cycle of playback, checked against the model.
    task automatic step(input logic r, input logic ld, input logic [PHASE_W-1:0] w);
        int   inc, idx;
        exp_t e;
        @(posedge clk); #1;
        run = r; freq_load = ld; freq_word = w;
        @(negedge clk);
        if (out_v) got.push_back(int'(out_sample));
        if (expq.size() > 0 && expq[0].due == cyc) begin
            chk($sformatf("out_v@%0d", cyc), int'(out_v), 1);
            chk($sformatf("out_sample@%0d", cyc), int'(out_sample), expq[0].val);
            last = expq[0].val;
            void'(expq.pop_front());
        end else begin
            chk($sformatf("out_v_idle@%0d", cyc), int'(out_v), 0);
            chk($sformatf("hold@%0d", cyc), int'(out_sample), last);
        end
        if (c % DIV == 0) begin
            inc = m_pend_v ? m_pend : m_freq;
            idx = ((m_phase / 256) * DEPTH) / 65536;
            e.due = cyc + LAT;
            e.val = r ? scale(tbl[idx]) : int'(MIDSCALE);
            expq.push_back(e);
            m_freq   = inc;
            m_pend_v = 0;
            m_phase  = r ? (m_phase + inc) % (1 << PHASE_W) : 0;
        end
        if (ld) begin
            m_pend   = int'(w);
            m_pend_v = 1;
        end
        c++;
        cyc++;
    endtask

    task automatic enter_play();
        @(posedge clk); #1 in_done = 1'b1;
        @(negedge clk);
        chk("ready_before", int'(ready), 0);
        step(1'b0, 1'b0, '0);
        chk("ready_after", int'(ready), 1);
    endtask

    // Idle with run=0 until a tick has latched w and zeroed the phase.
    task automatic prep(input logic [PHASE_W-1:0] w);
        bit seen;
        seen = 1'b0;
        step(1'b0, 1'b1, w);
        while (!(seen && (c % DIV == 1))) begin
            if (c % DIV == 0) seen = 1'b1;
            step(1'b0, 1'b0, '0);
        end
    endtask

    // Run from a tick boundary and gather the DUT outputs of nticks ticks.
    task automatic collect(input int nticks, input int ld_at, input logic [PHASE_W-1:0] ldw);
        while (c % DIV != 0) step(1'b1, 1'b0, '0);
        got.delete();
        for (int k = 0; k < nticks * DIV + LAT; k++) begin
            step(1'b1, k == ld_at, (k == ld_at) ? ldw : '0);
        end
    endtask

    task automatic cmp_got(input string name, input int i, input int exp);
        if (got.size() > i) chk(name, got[i], exp);
        else chk({name, "_count"}, got.size(), i + 1);
    endtask

    initial begin
        int exp_a [7];
        int exp_b [5];
        exp_a = '{0, 180, 0, 90, 180, 270, 0};
        exp_b = '{0, 180, 270, 0, 90};
        vecs[0] = '{24'h000000, 0, 0, 0, 0};
        vecs[1] = '{24'h400000, 0, 90, 180, 270};
        vecs[2] = '{24'h800000, 0, 180, 0, 180};
        vecs[3] = '{24'h200000, 0, 45, 90, 135};
        vecs[4] = '{24'hC00000, 0, 270, 180, 90};
        amp = 8'd128;

        // Ramp table, slow strobes
        do_reset();
        for (int i = 0; i < DEPTH; i++) vals[i] = i;
        load(DEPTH, 20);
        enter_play();
        chk("ramp_ovf", int'(ovf), 0);
        chk("ramp_err", int'(err), 0);

        for (int v = 0; v < 5; v++) begin
            prep(vecs[v].word);
            collect(4, -1, '0);
            cmp_got($sformatf("vec%0d_s0", v), 0, scale(vecs[v].e0));
            cmp_got($sformatf("vec%0d_s1", v), 1, scale(vecs[v].e1));
            cmp_got($sformatf("vec%0d_s2", v), 2, scale(vecs[v].e2));
            cmp_got($sformatf("vec%0d_s3", v), 3, scale(vecs[v].e3));
        end

        // Frequency change mid-sample, then coinciding with a tick
        prep(24'h800000);
        collect(7, 6, 24'h400000);
        for (int i = 0; i < 7; i++) cmp_got($sformatf("fmid_s%0d", i), i, scale(exp_a[i]));
        prep(24'h800000);
        collect(5, 0, 24'h400000);
        for (int i = 0; i < 5; i++) cmp_got($sformatf("ftick_s%0d", i), i, scale(exp_b[i]));

        // Overflow: 361 samples, the last one dropped
        do_reset();
        for (int i = 0; i <= DEPTH; i++) vals[i] = (i * 7 + 3) % 512;
        load(DEPTH + 1, 2);
        enter_play();
        chk("ovf_set", int'(ovf), 1);
        chk("ovf_err", int'(err), 0);
        prep(24'hFFFF00);
        collect(2, -1, '0);
        cmp_got("ovf_entry0", 0, scale(3));
        cmp_got("ovf_entry359", 1, scale(468));

        // Randomized playback against the model
        do_reset();
        for (int i = 0; i < DEPTH; i++) vals[i] = int'($urandom_range(0, 511));
        load(DEPTH, 2);
        enter_play();
        for (int k = 0; k < 1500; k++) begin
            step($urandom_range(0, 9) < 8, $urandom_range(0, 9) == 0, PHASE_W'($urandom));
        end
        @(posedge clk); #1 rst_n = 1'b0;
        #1;
        chk("async_rst_sample", int'(out_sample), 255);
        chk("async_rst_ready", int'(ready), 0);
        chk("async_rst_out_v", int'(out_v), 0);

        // Short table goes to ERR
        do_reset();
        for (int i = 0; i < DEPTH; i++) vals[i] = i;
        load(100, 2);
        @(posedge clk); #1 in_done = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            run = 1'b1; in_v = k[0]; freq_load = k[1]; freq_word = 24'h400000;
            @(negedge clk);
            chk($sformatf("err_out_v%0d", k), int'(out_v), 0);
            if (k > 0) begin
                chk($sformatf("err_flag%0d", k), int'(err), 1);
                chk($sformatf("err_ready%0d", k), int'(ready), 0);
                chk($sformatf("err_sample%0d", k), int'(out_sample), 255);
            end
        end

`ifdef WAVE_PLAYER_AMPLITUDE_EN
        // Gain stage: full-scale entry at half gain, then zero gain
        do_reset();
        vals[0] = 511;
        for (int i = 1; i < DEPTH; i++) vals[i] = i;
        load(DEPTH, 2);
        enter_play();
        prep(24'h000000);
        collect(2, -1, '0);
        cmp_got("amp128_s0", 0, 383);
        cmp_got("amp128_s1", 1, 383);
        repeat (4) step(1'b0, 1'b0, '0);
        amp = 8'd0;
        prep(24'h000000);
        collect(2, -1, '0);
        cmp_got("amp0_s0", 0, 255);
        cmp_got("amp0_s1", 1, 255);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wave_player.md
# wave_player

Downstream consumer of the sine-table initializer. It captures the stream of BITWIDTH-bit samples and the completion flag into an internal waveform RAM, then replays the table with a DDS phase accumulator to produce a periodic sample stream for the DAC driver. The sample encoding matches the upstream stage: all-zeros = 0.0, midscale = 0.5, all-ones = 1.0.

## Interface
- BITWIDTH, 9, sample width
- DEPTH, 360, table entries (one per degree)
- ADDR_W, 9, RAM address width; ceil(log2(DEPTH))
- PHASE_W, 24, phase accumulator width
- DIV, 4, clocks per output sample (≥3)

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- in_data  in  BITWIDTH  table sample from initializer
- in_v  in  1  one-cycle strobe; in_data is valid on the cycle after in_v
- in_done  in  1  level, table complete (upstream `initialized`)
- freq_word  in  PHASE_W  phase increment per output sample
- freq_load  in  1  pulse, latch freq_word
- run  in  1  level, enable playback
- out_sample  out  BITWIDTH  DAC sample
- out_v  out  1  one-cycle strobe per new out_sample
- ready  out  1  table loaded, playback possible
- ovf  out  1  sticky, more than DEPTH samples received
- err  out  1  sticky, in_done arrived with fewer than DEPTH samples

## Operation
- Reset: state LOAD, wr_addr=0, phase=0, active freq=0, out_sample=MIDSCALE (2^(BITWIDTH-1)-1, i.e. 255), out_v=0, ready=0, ovf=0, err=0.
- LOAD:
  - in_v is registered (in_v_d).
  - When in_v_d=1 and wr_addr<DEPTH, in_data is written at wr_addr and wr_addr increments.
  - When in_v_d=1 and wr_addr==DEPTH, the sample is dropped and ovf is set.
  - When in_done=1 and no write is pending: if wr_addr==DEPTH, go to PLAY and set ready=1 the next cycle; otherwise go to ERR and set err=1.
- ERR: terminal until reset. out_sample=MIDSCALE, out_v=0.
- PLAY:
  - A divider counts 0..DIV-1. The tick fires when the count is 0.
  - On a tick with run=1: phase += freq (mod 2^PHASE_W).
  - On a tick with run=0: phase=0 and out_sample is forced to MIDSCALE with out_v=1.
  - Index = (phase[PHASE_W-1:PHASE_W-16] × DEPTH) >> 16. This is an unsigned 16×ADDR_W product, and the result is always <DEPTH.
- freq_load: freq_word goes into a pending register. It is copied into the active freq at the next tick (not mid-sample). Simultaneous freq_load and tick: the new value is used at the following tick.
- in_v in PLAY or ERR: ignored, table unchanged.

## Timing
- Load write latency: in_v at cycle t → RAM write at t+1.
- ready rises 1 cycle after the accepted in_done.
- Playback pipeline, tick at cycle t:
  - t+1: index registered.
  - t+2: RAM read data registered into out_sample, out_v=1 for one cycle.
- Total latency is 2 cycles (3 with WAVE_PLAYER_AMPLITUDE_EN). The sample is held until the next out_v.
- Reset mid-operation: every output returns to its reset value asynchronously, and the table is reloaded from scratch.

## Configuration
- WAVE_PLAYER_AMPLITUDE_EN defined:
  - Adds port amp (in, 8), an unsigned gain.
  - out_sample = MIDSCALE + ((s − MIDSCALE) × amp) >>> 8, using a signed BITWIDTH+1 difference and arithmetic shift, saturated to 0..2^BITWIDTH−1.
  - Adds one pipeline stage, so out_v fires at t+3.
  - amp=0 gives constant MIDSCALE; amp=255 gives 255/256 of full swing.
- Not defined: no amp port, raw table samples, latency 2.

## Structure
- Package wave_pkg: BITWIDTH, DEPTH, ADDR_W, MIDSCALE constants, and the state enum {LOAD, PLAY, ERR}.
- Sub-module wave_ram: simple dual-port synchronous RAM, DEPTH×BITWIDTH, one write port and one registered read port, no reset on contents.
- Top level holds the FSM, write counter, divider, phase accumulator, index multiplier and output stage.

## Test plan
- Load a ramp of samples 0..359 (value=index) with in_v every 20 cycles, then in_done → ready=1 one cycle after in_done, err=0, ovf=0. With freq_word=0 and run=1, every out_v gives out_sample=0.
- Same table, freq_word=0x400000, DIV=4 → out_sample sequence 0, 90, 180, 270, 0, … with out_v exactly every 4 cycles, 2 cycles after each tick.
- freq_word=0x800000, then freq_load of 0x400000 mid-sample → the alternation 0, 180 continues until the next tick, then the 90-step sequence starts.
- 361 in_v strobes then in_done → ovf=1, ready=1, table entry 359 keeps sample #359 (the 361st sample is dropped).
- 100 samples then in_done → err=1, ready=0, out_sample=255, out_v never asserted. Assert rst_n low during PLAY → out_sample=255, ready=0 immediately.
- (WAVE_PLAYER_AMPLITUDE_EN) table entry 511 with amp=128 → out_sample=383. amp=0 → 255. out_v at t+3.
